// File: rtl/pcpi_div_share_if.sv
// Requester-side and PCPI-side signals of the shared divider controller.
// The controller uses the slave modport; the environment uses master.
interface pcpi_div_share_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [2*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_rs1;
    logic [32*NREQ-1:0] req_rs2;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               div_valid;
    logic [31:0]        div_insn;
    logic [31:0]        div_rs1;
    logic [31:0]        div_rs2;
    logic               div_wr;
    logic [31:0]        div_rd;
    logic               div_wait;
    logic               div_ready;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2,
        output div_wr, div_rd, div_wait, div_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  div_valid, div_insn, div_rs1, div_rs2
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2,
        input  div_wr, div_rd, div_wait, div_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output div_valid, div_insn, div_rs1, div_rs2
    );
endinterface

// File: rtl/pcpi_div_share.sv
// Round-robin controller time-sharing one PCPI divide/remainder unit among
// NREQ requesters, with a watchdog that aborts an operation the divider
// never completes.
module pcpi_div_share #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            resetn,
    pcpi_div_share_if.slave bus
);
    localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [RRW-1:0] rr_q;
    logic [RRW-1:0] winner;
    logic [RRW-1:0] cand;
    logic [WDW-1:0] wd_q;
    logic           found;
    logic           grant;
    logic           wd_expired;
    logic           unused_wr;

    logic [31:0] rs1_arr [NREQ];
    logic [31:0] rs2_arr [NREQ];
    logic [1:0]  op_arr  [NREQ];

    // The divider's write strobe carries no information beyond div_ready.
    assign unused_wr = bus.div_wr;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign rs1_arr[g] = bus.req_rs1[32*g +: 32];
        assign rs2_arr[g] = bus.req_rs2[32*g +: 32];
        assign op_arr[g]  = bus.req_op[2*g +: 2];
    end

    // Round-robin search: first pending requester after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        cand   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = RRW'((32'(rr_q) + i) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A busy or just-finished divider blocks grants, so a stale result left
    // over from an aborted operation is never credited to a new request.
    assign grant      = resetn && (state_q == IDLE) && found && !bus.div_wait && !bus.div_ready;
    assign wd_expired = (wd_q == WDW'(TIMEOUT));

    // Next-state logic plus the two combinational pulse outputs.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    bus.req_ready[winner] = 1'b1;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.div_ready || wd_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[rr_q] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, operand capture, PCPI handshake and result register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            rr_q          <= RRW'(NREQ - 1);
            wd_q          <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.div_valid <= 1'b0;
            bus.div_insn  <= '0;
            bus.div_rs1   <= '0;
            bus.div_rs2   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        rr_q          <= winner;
                        wd_q          <= '0;
                        bus.div_rs1   <= rs1_arr[winner];
                        bus.div_rs2   <= rs2_arr[winner];
                        bus.div_insn  <= {7'b0000001, 10'b0, 1'b1, op_arr[winner], 5'b0, 7'b0110011};
                        bus.div_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    wd_q <= wd_q + WDW'(1);
                    // div_valid drops on the same edge that samples div_ready,
                    // otherwise the divider would decode the instruction again.
                    if (bus.div_ready) begin
                        bus.rsp_data  <= bus.div_rd;
                        bus.rsp_err   <= 1'b0;
                        bus.div_valid <= 1'b0;
                    end else if (wd_expired) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.div_valid <= 1'b0;
                    end
                end
                RESP: begin
                    wd_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_div_share.sv
// Directed bench for pcpi_div_share with a behavioural multi-cycle divider
// that can be switched into a hung mode to exercise the watchdog.
module tb_pcpi_div_share;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned DIV_LAT = 6;

    logic clk;
    logic resetn;
    logic stub_mode;
    int unsigned checks;
    int unsigned passes;
    int unsigned start_count;

    logic        busy;
    int unsigned cnt;
    logic [31:0] res_q;

    pcpi_div_share_if #(.NREQ(NREQ)) bus ();

    pcpi_div_share #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rv32m(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (op)
            2'b00: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            2'b01: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Divider model: starts on a decoded valid, answers DIV_LAT+1 cycles later;
    // in stub mode it raises div_wait on a request and never finishes.
    always @(posedge clk) begin
        if (!resetn) begin
            busy          <= 1'b0;
            cnt           <= 0;
            res_q         <= '0;
            bus.div_wait  <= 1'b0;
            bus.div_ready <= 1'b0;
            bus.div_wr    <= 1'b0;
            bus.div_rd    <= '0;
        end else begin
            bus.div_ready <= 1'b0;
            bus.div_wr    <= 1'b0;
            if (stub_mode) begin
                if (bus.div_valid) bus.div_wait <= 1'b1;
            end else if (!busy && bus.div_valid && !bus.div_ready &&
                         bus.div_insn[6:0] == 7'b0110011 && bus.div_insn[31:25] == 7'b0000001 &&
                         bus.div_insn[14]) begin
                busy         <= 1'b1;
                bus.div_wait <= 1'b1;
                cnt          <= DIV_LAT;
                res_q        <= rv32m(bus.div_insn[13:12], bus.div_rs1, bus.div_rs2);
                start_count  <= start_count + 1;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy          <= 1'b0;
                    bus.div_wait  <= 1'b0;
                    bus.div_ready <= 1'b1;
                    bus.div_wr    <= 1'b1;
                    bus.div_rd    <= res_q;
                end else begin
                    cnt <= cnt - 1;
                end
            end else begin
                bus.div_wait <= 1'b0;
            end
        end
    end

    task automatic set_req(input int unsigned idx, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[2*idx +: 2]   = op;
        bus.req_rs1[32*idx +: 32] = a;
        bus.req_rs2[32*idx +: 32] = b;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One full transaction on requester idx, checking grant, issue and response.
    task automatic do_op(input int unsigned idx, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_d, input string name);
        int unsigned     cyc;
        int unsigned     extra;
        logic            got;
        logic [NREQ-1:0] onehot;
        logic [31:0]     exp_insn;
        onehot      = '0;
        onehot[idx] = 1'b1;
        exp_insn    = 32'h0200_4033 | (32'(op) << 12);
        @(negedge clk);
        set_req(idx, op, a, b);
        bus.req_valid[idx] = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            #1;
            if (bus.req_ready[idx]) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (!got) $display("FAIL %s grant: no req_ready within %0d cycles", name, cyc); else passes++;
        checks++; if (bus.req_ready !== onehot) $display("FAIL %s req_ready: got %b expected %b", name, bus.req_ready, onehot); else passes++;
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        set_req(idx, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
        #1;
        checks++; if (bus.div_valid !== 1'b1) $display("FAIL %s div_valid: got %b expected 1", name, bus.div_valid); else passes++;
        checks++; if (bus.div_insn !== exp_insn) $display("FAIL %s div_insn: got %h expected %h", name, bus.div_insn, exp_insn); else passes++;
        checks++; if ({bus.div_rs1, bus.div_rs2} !== {a, b}) $display("FAIL %s operands: got %h/%h expected %h/%h", name, bus.div_rs1, bus.div_rs2, a, b); else passes++;
        extra = 0;
        got   = 1'b0;
        cyc   = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.req_ready != 0) extra++;
            if (bus.rsp_valid != 0) got = 1'b1;
        end
        checks++; if (!got) $display("FAIL %s response: no rsp_valid within %0d cycles", name, cyc); else passes++;
        checks++; if (bus.rsp_valid !== onehot) $display("FAIL %s rsp_valid: got %b expected %b", name, bus.rsp_valid, onehot); else passes++;
        checks++; if (bus.rsp_data !== exp_d) $display("FAIL %s rsp_data: got %h expected %h", name, bus.rsp_data, exp_d); else passes++;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL %s rsp_err: got %b expected 0", name, bus.rsp_err); else passes++;
        checks++; if (extra != 0) $display("FAIL %s extra req_ready: got %0d expected 0", name, extra); else passes++;
        @(negedge clk);
        #1;
        checks++; if (bus.rsp_valid !== '0) $display("FAIL %s rsp pulse width: rsp_valid %b expected 00", name, bus.rsp_valid); else passes++;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        stub_mode     = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (bus.req_ready !== '0) $display("FAIL reset req_ready: got %b expected 00", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== '0) $display("FAIL reset rsp_valid: got %b expected 00", bus.rsp_valid); else passes++;
        checks++; if ({bus.rsp_err, bus.rsp_data} !== 33'h0) $display("FAIL reset rsp: got err %b data %h expected 0", bus.rsp_err, bus.rsp_data); else passes++;
        checks++; if (bus.div_valid !== 1'b0) $display("FAIL reset div_valid: got %b expected 0", bus.div_valid); else passes++;
        checks++; if ({bus.div_insn, bus.div_rs1, bus.div_rs2} !== 96'h0) $display("FAIL reset div regs: got %h %h %h expected 0", bus.div_insn, bus.div_rs1, bus.div_rs2); else passes++;
    endtask

    task automatic test_single_div();
        do_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    endtask

    task automatic test_corners();
        do_op(1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(0, 2'b01, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        do_op(1, 2'b11, 32'd100, 32'd0, 32'd100, "remu_by0");
        do_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
    endtask

    task automatic test_fairness();
        int unsigned     ng;
        int unsigned     nr;
        int unsigned     cyc;
        logic [NREQ-1:0] exp_g;
        logic [NREQ-1:0] exp_r;
        logic [31:0]     exp_d;
        do_reset();
        set_req(0, 2'b00, 32'd10, 32'd3);
        set_req(1, 2'b11, 32'd10, 32'd3);
        bus.req_valid = 2'b11;
        ng  = 0;
        nr  = 0;
        cyc = 0;
        while (nr < 4 && cyc < 400) begin
            #1;
            if (bus.req_ready != 0) begin
                exp_g = (ng % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (bus.req_ready !== exp_g) $display("FAIL fair grant%0d: got %b expected %b", ng, bus.req_ready, exp_g); else passes++;
                ng++;
            end
            if (bus.rsp_valid != 0) begin
                exp_r = (nr % 2 == 0) ? 2'b01 : 2'b10;
                exp_d = (nr % 2 == 0) ? 32'd3 : 32'd1;
                checks++; if (bus.rsp_valid !== exp_r) $display("FAIL fair rsp%0d target: got %b expected %b", nr, bus.rsp_valid, exp_r); else passes++;
                checks++; if (bus.rsp_data !== exp_d) $display("FAIL fair rsp%0d data: got %h expected %h", nr, bus.rsp_data, exp_d); else passes++;
                nr++;
                if (nr == 4) bus.req_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = '0;
        checks++; if (nr != 4 || ng != 4) $display("FAIL fair count: got %0d grants %0d rsps expected 4/4", ng, nr); else passes++;
    endtask

    task automatic test_back_to_back();
        int unsigned s0;
        int unsigned nrsp;
        int unsigned cyc;
        int unsigned lowrun;
        logic        seen_high;
        logic        rdy_prev;
        s0 = start_count;
        @(negedge clk);
        set_req(0, 2'b01, 32'd20, 32'd4);
        bus.req_valid[0] = 1'b1;
        nrsp      = 0;
        cyc       = 0;
        lowrun    = 0;
        seen_high = 1'b0;
        rdy_prev  = 1'b0;
        while (nrsp < 2 && cyc < 300) begin
            #1;
            if (rdy_prev) begin
                checks++; if (bus.div_valid !== 1'b0) $display("FAIL b2b div_valid after ready: got %b expected 0", bus.div_valid); else passes++;
                checks++; if (bus.rsp_valid !== 2'b01) $display("FAIL b2b rsp after ready: got %b expected 01", bus.rsp_valid); else passes++;
            end
            if (bus.rsp_valid != 0) begin
                checks++; if (bus.rsp_data !== 32'd5) $display("FAIL b2b data: got %h expected 00000005", bus.rsp_data); else passes++;
                nrsp++;
                if (nrsp == 2) bus.req_valid[0] = 1'b0;
            end
            if (bus.div_valid) begin
                if (seen_high && lowrun > 0) begin
                    checks++; if (lowrun < 2) $display("FAIL b2b valid gap: got %0d cycles expected >=2", lowrun); else passes++;
                end
                seen_high = 1'b1;
                lowrun    = 0;
            end else begin
                lowrun++;
            end
            rdy_prev = bus.div_ready;
            @(negedge clk);
            cyc++;
        end
        bus.req_valid[0] = 1'b0;
        checks++; if (nrsp != 2) $display("FAIL b2b responses: got %0d expected 2", nrsp); else passes++;
        checks++; if (start_count - s0 != 2) $display("FAIL b2b divider starts: got %0d expected 2", start_count - s0); else passes++;
    endtask

    task automatic test_watchdog();
        int unsigned cyc;
        int          v_cyc;
        int          r_cyc;
        int unsigned grants;
        logic        got;
        stub_mode = 1'b1;
        @(negedge clk);
        set_req(0, 2'b01, 32'd7, 32'd7);
        bus.req_valid[0] = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            #1;
            if (bus.req_ready[0]) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (!got) $display("FAIL wdog grant: no req_ready within %0d cycles", cyc); else passes++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        v_cyc = -1;
        r_cyc = -1;
        cyc   = 0;
        while (r_cyc < 0 && cyc < 60) begin
            #1;
            if (v_cyc < 0 && bus.div_valid) v_cyc = int'(cyc);
            if (bus.rsp_valid != 0) r_cyc = int'(cyc);
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (v_cyc < 0 || r_cyc - v_cyc != 16) $display("FAIL wdog latency: got %0d cycles expected 16", r_cyc - v_cyc); else passes++;
        checks++; if (bus.rsp_valid !== 2'b01) $display("FAIL wdog rsp_valid: got %b expected 01", bus.rsp_valid); else passes++;
        checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 32'h0}) $display("FAIL wdog abort: got err %b data %h expected 1/0", bus.rsp_err, bus.rsp_data); else passes++;
        @(negedge clk);
        set_req(1, 2'b11, 32'd10, 32'd3);
        bus.req_valid[1] = 1'b1;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready != 0 || bus.div_valid) grants++;
            @(negedge clk);
        end
        checks++; if (grants != 0) $display("FAIL wdog blocked: got %0d grant cycles expected 0", grants); else passes++;
        bus.req_valid[1] = 1'b0;
        stub_mode = 1'b0;
        do_op(1, 2'b11, 32'd10, 32'd3, 32'd1, "after_wdog");
    endtask

    task automatic test_reset_mid_issue();
        int unsigned cyc;
        int unsigned stray;
        logic        got;
        stub_mode = 1'b1;
        @(negedge clk);
        set_req(0, 2'b00, 32'd1, 32'd1);
        bus.req_valid[0] = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            #1;
            if (bus.req_ready[0]) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (!got) $display("FAIL midrst grant: no req_ready within %0d cycles", cyc); else passes++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        resetn    = 1'b0;
        stub_mode = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.div_valid} !== '0) $display("FAIL midrst ctrl: got %b %b %b %b expected 0", bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.div_valid); else passes++;
        checks++; if ({bus.rsp_data, bus.div_insn, bus.div_rs1, bus.div_rs2} !== 128'h0) $display("FAIL midrst regs: got %h %h %h %h expected 0", bus.rsp_data, bus.div_insn, bus.div_rs1, bus.div_rs2); else passes++;
        resetn = 1'b1;
        stray  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != 0) stray++;
        end
        checks++; if (stray != 0) $display("FAIL midrst stray rsp: got %0d expected 0", stray); else passes++;
        do_op(0, 2'b01, 32'd9, 32'd3, 32'd3, "divu_after_rst");
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        start_count = 0;
        test_reset();
        test_single_div();
        test_corners();
        test_fairness();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
